gbuf_port_arbiter: RTL
======================

Name: gbuf_port_arbiter

Overview:
- Shares one single-port global buffer (1-cycle read latency BRAM) between two requesters: the host command path (operand load / result readback) and the TPU sequencer.
- Replaces hard mode-based muxing of buffer ports with request/grant arbitration: TPU priority, host anti-starvation, TPU burst lock, and read-data return routing.
- One instance per buffer (A, B, C), sitting between the CFU/TPU and each global_buffer_bram.

Parameters:
- ADDR_BITS, 14, buffer depth exponent; indices above this range are truncated (upper index bits ignored).
- DATA_BITS, 32, buffer word width (128 for the C buffer).
- MAX_WAIT, 8, host wait cycles before host gets forced priority; legal range 1..255.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- host_req  in  1  host requests one buffer access this cycle
- host_wr_en  in  1  1 = write, 0 = read
- host_index  in  16  word address
- host_data_in  in  DATA_BITS  write data
- host_gnt  out  1  host access performed this cycle (combinational)
- host_rvalid  out  1  host read data valid (registered)
- host_rdata  out  DATA_BITS  read data; 0 when host_rvalid=0
- tpu_req, tpu_wr_en, tpu_index, tpu_data_in, tpu_gnt, tpu_rvalid, tpu_rdata  same as host set, TPU side
- tpu_lock  in  1  TPU requests exclusive ownership starting at its next grant
- buf_ram_en  out  1  buffer enable = host_gnt | tpu_gnt
- buf_wr_en  out  1  winner's wr_en, 0 if no grant
- buf_index  out  16  winner's index, 0 if no grant
- buf_data_in  out  DATA_BITS  winner's data_in, 0 if no grant
- buf_data_out  in  DATA_BITS  buffer read data (valid 1 cycle after read)
- locked  out  1  FSM in LOCKED state
- conflict_cnt  out  16  saturating count of cycles with both requests asserted

Behaviour:
- Reset value of every output is 0 (gated rdata included); FSM = ARB; host_wait = 0; conflict_cnt = 0. Reset mid-access drops any pending rvalid; the read is not replayed.
- Grant is combinational: at most one of host_gnt/tpu_gnt per cycle, and never without the matching req. buf_* is muxed from the winner in the same cycle.
- FSM ARB, winner selection in priority order:
  - host_req and host_wait == MAX_WAIT → host;
  - else tpu_req → tpu;
  - else host_req → host.
- FSM ARB → LOCKED on a cycle where tpu_gnt=1 and tpu_lock=1.
- FSM LOCKED:
  - only the TPU may be granted; host_gnt is held 0.
  - LOCKED → ARB on the first rising edge where tpu_lock=0. The host is arbitrable in that following cycle.
- host_wait:
  - increments each cycle host_req=1 and host_gnt=0, saturating at MAX_WAIT;
  - clears on host_gnt;
  - holds when host_req=0.
- Read return: when a read is granted in cycle t, the owner's rvalid is 1 in cycle t+1 and rdata = buf_data_out; otherwise rdata = 0. A write grant produces no rvalid.
- Back-to-back reads by alternating owners each return to the correct owner: the owner tag is registered per cycle.
- conflict_cnt increments when host_req and tpu_req are both 1, saturating at 16'hFFFF.
- Requester contract: req, wr_en, index and data_in are held stable until gnt. Dropping req before gnt is legal and cancels the access without side effects.

Decomposition:
- Shared package holds:
  - state encoding ARB=1'b0, LOCKED=1'b1;
  - owner tag constants OWN_HOST=1'b0, OWN_TPU=1'b1;
  - the default MAX_WAIT.
- The arbiter is one module. No sub-module is needed beyond an optional gbuf_rd_return (1-deep owner-tag/rvalid pipe) when it is reused for the C buffer.

Test Plan:
- Reset: assert reset for 3 cycles with both reqs high → all outputs 0, locked=0. Release → tpu_gnt=1 in the first cycle.
- Idle host read: host read index 5, buffer word 5 = 32'hDEADBEEF → host_gnt in cycle t, host_rvalid=1 with host_rdata=32'hDEADBEEF at t+1, tpu_rvalid=0.
- Starvation: MAX_WAIT=8, tpu_req and host_req held for 20 cycles, no lock → tpu granted 8 cycles, host granted in cycle 9, then TPU again; conflict_cnt=20.
- Lock: TPU grant with tpu_lock=1, host_req held, lock high 12 cycles → host_gnt=0 throughout and locked=1. Host granted the cycle after tpu_lock falls, given host_wait saturated.
- Interleaved reads: TPU read idx 1 (value 0x11), then host read idx 2 (value 0x22) on consecutive cycles → tpu_rdata=0x11 then host_rdata=0x22, each rvalid exactly one cycle.
- Async reset mid-read: reset asserted between grant and return → no rvalid after reset; state ARB.

Source files
------------

// File: rtl/gbuf_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// gbuf_port_arbiter_pkg : shared encodings for the global-buffer port arbiter
// Revision: 1.0
// ============================================================================
package gbuf_port_arbiter_pkg;

    localparam logic [0:0] ARB      = 1'b0;
    localparam logic [0:0] LOCKED   = 1'b1;

    localparam logic [0:0] OWN_HOST = 1'b0;
    localparam logic [0:0] OWN_TPU  = 1'b1;

    localparam int DEFAULT_MAX_WAIT = 8;

endpackage
`default_nettype wire

// File: rtl/gbuf_rd_return.sv
`default_nettype none
// ============================================================================
// gbuf_rd_return : 1-deep owner-tag / rvalid pipe matching BRAM read latency
// Revision: 1.0
// ============================================================================
module gbuf_rd_return
    import gbuf_port_arbiter_pkg::*;
#(
    parameter int DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rd_fire,
    input  logic                 rd_owner,
    input  logic [DATA_BITS-1:0] buf_data_out,
    output logic                 host_rvalid,
    output logic [DATA_BITS-1:0] host_rdata,
    output logic                 tpu_rvalid,
    output logic [DATA_BITS-1:0] tpu_rdata
);

    logic valid_q, valid_d;
    logic owner_q, owner_d;

    always_comb begin
        valid_d = rd_fire;
        owner_d = rd_owner;
    end

    // A reset between grant and return discards the read; it is never replayed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            owner_q <= OWN_HOST;
        end else begin
            valid_q <= valid_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        host_rvalid = valid_q && (owner_q == OWN_HOST);
        tpu_rvalid  = valid_q && (owner_q == OWN_TPU);
        host_rdata  = host_rvalid ? buf_data_out : '0;
        tpu_rdata   = tpu_rvalid  ? buf_data_out : '0;
    end

endmodule
`default_nettype wire

// File: rtl/gbuf_port_arbiter.sv
`default_nettype none
// ============================================================================
// gbuf_port_arbiter : host/TPU request-grant arbiter for one global buffer
// Revision: 1.0
// ============================================================================
module gbuf_port_arbiter
    import gbuf_port_arbiter_pkg::*;
#(
    parameter int ADDR_BITS = 14,
    parameter int DATA_BITS = 32,
    parameter int MAX_WAIT  = DEFAULT_MAX_WAIT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 host_req,
    input  logic                 host_wr_en,
    input  logic [15:0]          host_index,
    input  logic [DATA_BITS-1:0] host_data_in,
    output logic                 host_gnt,
    output logic                 host_rvalid,
    output logic [DATA_BITS-1:0] host_rdata,
    input  logic                 tpu_req,
    input  logic                 tpu_wr_en,
    input  logic [15:0]          tpu_index,
    input  logic [DATA_BITS-1:0] tpu_data_in,
    output logic                 tpu_gnt,
    output logic                 tpu_rvalid,
    output logic [DATA_BITS-1:0] tpu_rdata,
    input  logic                 tpu_lock,
    output logic                 buf_ram_en,
    output logic                 buf_wr_en,
    output logic [15:0]          buf_index,
    output logic [DATA_BITS-1:0] buf_data_in,
    input  logic [DATA_BITS-1:0] buf_data_out,
    output logic                 locked,
    output logic [15:0]          conflict_cnt
);

    localparam logic [7:0]  c_max_wait = 8'(MAX_WAIT);
    localparam logic [15:0] c_idx_mask = 16'((32'd1 << ADDR_BITS) - 32'd1);

    logic [0:0]  state_q, state_d;
    logic [7:0]  host_wait_q, host_wait_d;
    logic [15:0] conflict_cnt_q, conflict_cnt_d;
    logic        rd_fire_w;
    logic        rd_owner_w;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:     if (tpu_gnt && tpu_lock) state_d = LOCKED;
            LOCKED:  if (!tpu_lock)           state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    // FSM outputs: grants are combinational and suppressed while in reset
    always_comb begin
        host_gnt = 1'b0;
        tpu_gnt  = 1'b0;
        if (!reset) begin
            case (state_q)
                ARB: begin
                    if (host_req && (host_wait_q == c_max_wait)) host_gnt = 1'b1;
                    else if (tpu_req)                            tpu_gnt  = 1'b1;
                    else if (host_req)                           host_gnt = 1'b1;
                end
                LOCKED:  tpu_gnt = tpu_req;
                default: ;
            endcase
        end
        locked = (state_q == LOCKED);
    end

    always_comb begin
        buf_ram_en  = host_gnt | tpu_gnt;
        buf_wr_en   = 1'b0;
        buf_index   = '0;
        buf_data_in = '0;
        if (host_gnt) begin
            buf_wr_en   = host_wr_en;
            buf_index   = host_index & c_idx_mask;
            buf_data_in = host_data_in;
        end else if (tpu_gnt) begin
            buf_wr_en   = tpu_wr_en;
            buf_index   = tpu_index & c_idx_mask;
            buf_data_in = tpu_data_in;
        end
        rd_fire_w  = (host_gnt && !host_wr_en) || (tpu_gnt && !tpu_wr_en);
        rd_owner_w = tpu_gnt ? OWN_TPU : OWN_HOST;
    end

    always_comb begin
        host_wait_d = host_wait_q;
        if (host_gnt) begin
            host_wait_d = '0;
        end else if (host_req && (host_wait_q < c_max_wait)) begin
            host_wait_d = host_wait_q + 8'd1;
        end

        conflict_cnt_d = conflict_cnt_q;
        if (host_req && tpu_req && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            host_wait_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            host_wait_q    <= host_wait_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign conflict_cnt = conflict_cnt_q;

    gbuf_rd_return #(
        .DATA_BITS (DATA_BITS)
    ) u_rd_return (
        .clk          (clk),
        .reset        (reset),
        .rd_fire      (rd_fire_w),
        .rd_owner     (rd_owner_w),
        .buf_data_out (buf_data_out),
        .host_rvalid  (host_rvalid),
        .host_rdata   (host_rdata),
        .tpu_rvalid   (tpu_rvalid),
        .tpu_rdata    (tpu_rdata)
    );

endmodule
`default_nettype wire
